// File: rtl/adc_frame_sequencer_if.sv
// ADC front-end request/ack handshake plus the RAW register-file write port.
// The sequencer drives through 'master'; the front-end/register side uses 'slave'.
interface adc_frame_sequencer_if #(
  parameter int unsigned ADC_BITS = 24
);
  logic                adc_req;
  logic [2:0]          adc_ch;
  logic                adc_ack;
  logic [ADC_BITS-1:0] adc_data;
  logic                raw_we;
  logic [2:0]          raw_idx;
  logic [31:0]         raw_data;

  modport master (
    output adc_req, adc_ch, raw_we, raw_idx, raw_data,
    input  adc_ack, adc_data
  );

  modport slave (
    input  adc_req, adc_ch, raw_we, raw_idx, raw_data,
    output adc_ack, adc_data
  );
endinterface

// File: rtl/adc_frame_sequencer.sv
// Captures one frame of 1..8 ADC channels into the RAW slots, on software or periodic
// triggers, with per-channel timeout, dropped-trigger detection and a frame counter.
module adc_frame_sequencer #(
  parameter int unsigned ADC_BITS       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned PERIOD_W       = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic                snapshot_i,
  input  logic [3:0]          num_ch_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                clr_err_i,
  adc_frame_sequencer_if.master bus,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [31:0]         frame_cnt_o,
  output logic                err_timeout_o,
  output logic                err_overrun_o
);

  localparam int unsigned   TmoW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   Sentinel = 32'h8000_0000;

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [3:0]          n_q, n_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [31:0]         sample_q, sample_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [31:0]         frame_cnt_q, frame_cnt_d;
  logic                err_tmo_q, err_tmo_d;
  logic                err_ovr_q, err_ovr_d;

  logic                   per_run, per_tick, trigger, set_tmo, set_ovr;
  logic [3:0]             n_clamp;
  logic signed [ADC_BITS-1:0] adc_sample;

  assign adc_sample = bus.adc_data;
  assign n_clamp    = (num_ch_i > 4'd8) ? 4'd8 : num_ch_i;

  // Free-running interval timer; its tick is just another trigger source.
  assign per_run  = enable_i && (period_i != '0);
  assign per_tick = per_run && (per_q == period_i - PERIOD_W'(1));
  assign trigger  = enable_i && (start_i || snapshot_i || per_tick);
  assign set_ovr  = trigger && (state_q != StIdle);

  always_comb begin
    per_d = '0;
    if (per_run && !per_tick) begin
      per_d = per_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    n_d      = n_q;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    set_tmo  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          n_d     = n_clamp;
          ch_d    = '0;
          tmo_d   = '0;
          state_d = (n_clamp == 4'd0) ? StDone : StReq;
        end
      end
      StReq: begin
        // Losing enable abandons the frame quietly: no sentinel, no error.
        if (!enable_i) begin
          state_d = StIdle;
        end else if (bus.adc_ack) begin
          sample_d = 32'(adc_sample);
          state_d  = StWrite;
        end else if (tmo_q == TmoLast) begin
          sample_d = Sentinel;
          set_tmo  = 1'b1;
          state_d  = StWrite;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWrite: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if ({1'b0, ch_q} == (n_q - 4'd1)) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 3'd1;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == StDone) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  // A new error event in the same cycle as a clear keeps the flag set.
  always_comb begin
    err_tmo_d = err_tmo_q;
    err_ovr_d = err_ovr_q;
    if (clr_err_i) begin
      err_tmo_d = 1'b0;
      err_ovr_d = 1'b0;
    end
    if (set_tmo) begin
      err_tmo_d = 1'b1;
    end
    if (set_ovr) begin
      err_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      n_q         <= '0;
      tmo_q       <= '0;
      sample_q    <= '0;
      per_q       <= '0;
      frame_cnt_q <= '0;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      n_q         <= n_d;
      tmo_q       <= tmo_d;
      sample_q    <= sample_d;
      per_q       <= per_d;
      frame_cnt_q <= frame_cnt_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign bus.adc_req  = (state_q == StReq);
  assign bus.adc_ch   = (state_q == StReq) ? ch_q : 3'd0;
  assign bus.raw_we   = (state_q == StWrite);
  assign bus.raw_idx  = (state_q == StWrite) ? ch_q : 3'd0;
  assign bus.raw_data = (state_q == StWrite) ? sample_q : 32'd0;

  assign busy_o        = (state_q == StReq) || (state_q == StWrite);
  assign frame_done_o  = (state_q == StDone);
  assign frame_cnt_o   = frame_cnt_q;
  assign err_timeout_o = err_tmo_q;
  assign err_overrun_o = err_ovr_q;

endmodule
